// File: rtl/vscale_operand_b_stage_pkg.sv
// Local types and helpers for the operand-B stage.
package vscale_operand_b_stage_pkg;

  localparam int REG_IDX_W = 5;
  localparam int HITS_W    = 16;

  // Counter bump that sticks at all-ones instead of wrapping.
  function automatic logic [HITS_W-1:0] sat_inc(input logic [HITS_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/vscale_ctrl_constants.vh
// Shared control constants: operand-B select codes and select width.
`ifndef VSCALE_CTRL_CONSTANTS_VH
`define VSCALE_CTRL_CONSTANTS_VH

`define SRC_B_SEL_W 3
`define SRC_B_RS2   3'd0
`define SRC_B_IMM   3'd1
`define SRC_B_FOUR  3'd2
`define SRC_B_ZERO  3'd3

`endif

// File: rtl/vscale_skid_buf2.sv
// Two-entry in-order operand buffer; ready depends on held count only.
module vscale_skid_buf2 #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop_ready,
  input  logic             flush,
  output logic             not_full,
  output logic             not_empty,
  output logic [WIDTH-1:0] head_data
);

  logic [WIDTH-1:0] r_mem [2];
  logic             r_wr_ptr;
  logic             r_rd_ptr;
  logic [1:0]       r_count;
  logic             w_pop;

  assign not_full  = (r_count < 2'd2);
  assign not_empty = (r_count != 2'd0);
  assign head_data = r_mem[r_rd_ptr];
  assign w_pop     = not_empty && pop_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else if (flush) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (push) begin
        r_mem[r_wr_ptr] <= push_data;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      r_count <= r_count + {1'b0, push} - {1'b0, w_pop};
    end
  end

endmodule

// File: rtl/vscale_operand_b_stage.sv
// Operand-B select with bypass forwarding, buffered through a 2-entry queue.
`include "vscale_ctrl_constants.vh"

module vscale_operand_b_stage
  import vscale_operand_b_stage_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int NBYP  = 2,
  parameter int SEL_W = `SRC_B_SEL_W
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [SEL_W-1:0]     src_b_sel,
  input  logic [REG_IDX_W-1:0] rs2_addr,
  input  logic [XLEN-1:0]      rs2_data,
  input  logic [XLEN-1:0]      imm,
  input  logic [NBYP-1:0]      byp_valid,
  input  logic [5*NBYP-1:0]    byp_addr,
  input  logic [XLEN*NBYP-1:0] byp_data,
  input  logic                 flush,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [XLEN-1:0]      alu_src_b,
  output logic [HITS_W-1:0]    byp_hits
);

  logic [NBYP-1:0]   w_match;
  logic              w_fwd_hit;
  logic [XLEN-1:0]   w_fwd_data;
  logic [XLEN-1:0]   w_operand;
  logic              w_from_byp;
  logic              w_push;
  logic [HITS_W-1:0] r_byp_hits;

  // x0 never matches, so a write-back aimed at x0 cannot leak through.
  for (genvar gi = 0; gi < NBYP; gi++) begin : g_match
    assign w_match[gi] = byp_valid[gi]
                      && (byp_addr[5*gi +: 5] == rs2_addr)
                      && (rs2_addr != '0);
  end

  always_comb begin
    w_fwd_hit  = 1'b0;
    w_fwd_data = rs2_data;
    for (int i = NBYP - 1; i >= 0; i--) begin
      if (w_match[i]) begin
        w_fwd_hit  = 1'b1;
        w_fwd_data = byp_data[XLEN*i +: XLEN];
      end
    end
  end

  always_comb begin
    w_operand  = '0;
    w_from_byp = 1'b0;
    case (src_b_sel)
      `SRC_B_RS2: begin
        if (rs2_addr != '0) begin
          w_operand  = w_fwd_data;
          w_from_byp = w_fwd_hit;
        end
      end
      `SRC_B_IMM:  w_operand = imm;
      `SRC_B_FOUR: w_operand = XLEN'(4);
      default:     w_operand = '0;
    endcase
  end

  assign w_push = in_valid && in_ready;

  vscale_skid_buf2 #(
    .WIDTH (XLEN)
  ) u_buf (
    .clk       (clk),
    .rst_n     (reset_n),
    .push      (w_push),
    .push_data (w_operand),
    .pop_ready (out_ready),
    .flush     (flush),
    .not_full  (in_ready),
    .not_empty (out_valid),
    .head_data (alu_src_b)
  );

  // Counts accepted bypass pushes even when a flush throws the operand away.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_byp_hits <= '0;
    end else if (w_push && w_from_byp) begin
      r_byp_hits <= sat_inc(r_byp_hits);
    end
  end

  assign byp_hits = r_byp_hits;

endmodule

// File: tb/tb_vscale_operand_b_stage.sv
// Directed self-checking bench for vscale_operand_b_stage.
`include "vscale_ctrl_constants.vh"

module tb_vscale_operand_b_stage;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  src_b_sel;
  logic [4:0]  rs2_addr;
  logic [31:0] rs2_data;
  logic [31:0] imm;
  logic [1:0]  byp_valid;
  logic [9:0]  byp_addr;
  logic [63:0] byp_data;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] alu_src_b;
  logic [15:0] byp_hits;

  int checks = 0;
  int errors = 0;

  vscale_operand_b_stage dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .src_b_sel (src_b_sel),
    .rs2_addr  (rs2_addr),
    .rs2_data  (rs2_data),
    .imm       (imm),
    .byp_valid (byp_valid),
    .byp_addr  (byp_addr),
    .byp_data  (byp_data),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .alu_src_b (alu_src_b),
    .byp_hits  (byp_hits)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
    $display("check %-18s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic req_rs2(input logic [4:0] a, input logic [31:0] d);
    src_b_sel = `SRC_B_RS2;
    rs2_addr  = a;
    rs2_data  = d;
  endtask

  task automatic req_imm(input logic [31:0] v);
    src_b_sel = `SRC_B_IMM;
    imm       = v;
  endtask

  initial begin
    reset_n = 1'b0; in_valid = 1'b0; src_b_sel = `SRC_B_ZERO;
    rs2_addr = '0; rs2_data = '0; imm = '0;
    byp_valid = '0; byp_addr = '0; byp_data = '0;
    flush = 1'b0; out_ready = 1'b0;
    #2;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready",  {31'd0, in_ready},  32'd1);
    chk("rst_alu_src_b", alu_src_b, 32'd0);
    chk("rst_byp_hits",  {16'd0, byp_hits}, 32'd0);
    tick(); tick();
    #2 reset_n = 1'b1;
    tick();

    // Both channels match: channel 0 wins.
    out_ready = 1'b1;
    req_rs2(5'd5, 32'h11);
    byp_valid = 2'b11; byp_addr = {5'd5, 5'd5}; byp_data = {32'hBB, 32'hAA};
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    byp_data = {32'hDEAD, 32'hBEEF};
    chk("byp_ch0_wins", alu_src_b, 32'hAA);
    chk("byp_ch0_valid", {31'd0, out_valid}, 32'd1);
    chk("byp_hits_1", {16'd0, byp_hits}, 32'd1);
    tick();
    chk("drained_1", {31'd0, out_valid}, 32'd0);

    // Only channel 1 matches.
    byp_valid = 2'b10; byp_data = {32'hBB, 32'hAA}; in_valid = 1'b1;
    tick(); in_valid = 1'b0;
    chk("byp_ch1", alu_src_b, 32'hBB);
    chk("byp_hits_2", {16'd0, byp_hits}, 32'd2);
    tick();

    // Address mismatch falls back to register data.
    byp_valid = 2'b11; byp_addr = {5'd6, 5'd7}; in_valid = 1'b1;
    tick(); in_valid = 1'b0;
    chk("no_match_rf", alu_src_b, 32'h11);
    chk("no_match_hits", {16'd0, byp_hits}, 32'd2);
    tick();

    // x0 reads zero even with a valid forward to x0.
    req_rs2(5'd0, 32'h11); byp_valid = 2'b01; byp_addr = {5'd0, 5'd0}; in_valid = 1'b1;
    tick(); in_valid = 1'b0;
    chk("x0_zero", alu_src_b, 32'h0);
    chk("x0_hits", {16'd0, byp_hits}, 32'd2);
    tick();

    src_b_sel = `SRC_B_FOUR; in_valid = 1'b1;
    tick(); in_valid = 1'b0;
    chk("sel_four", alu_src_b, 32'h4);
    tick();
    imm = 32'h1234; src_b_sel = 3'd7; in_valid = 1'b1;
    tick(); in_valid = 1'b0;
    chk("sel_other_zero", alu_src_b, 32'h0);
    tick();

    // Fill two entries with no consumer, then drain in order.
    out_ready = 1'b0; byp_valid = 2'b00;
    req_imm(32'h1); in_valid = 1'b1;
    tick();
    chk("fill1_in_ready", {31'd0, in_ready}, 32'd1);
    chk("fill1_head", alu_src_b, 32'h1);
    req_imm(32'h2);
    tick(); in_valid = 1'b0;
    chk("full_in_ready", {31'd0, in_ready}, 32'd0);
    tick();
    chk("stall_hold", alu_src_b, 32'h1);
    out_ready = 1'b1;
    tick();
    chk("pop_second", alu_src_b, 32'h2);
    chk("pop_in_ready", {31'd0, in_ready}, 32'd1);
    tick();
    chk("drained_2", {31'd0, out_valid}, 32'd0);

    // Push and pop together with one entry held.
    out_ready = 1'b0; src_b_sel = `SRC_B_FOUR; in_valid = 1'b1;
    tick();
    chk("one_held_four", alu_src_b, 32'h4);
    req_imm(32'h7); out_ready = 1'b1;
    tick(); in_valid = 1'b0; out_ready = 1'b0;
    chk("pp_head", alu_src_b, 32'h7);
    chk("pp_valid", {31'd0, out_valid}, 32'd1);
    chk("pp_in_ready", {31'd0, in_ready}, 32'd1);
    out_ready = 1'b1;
    tick();
    chk("pp_count_one", {31'd0, out_valid}, 32'd0);

    // Flush a full buffer while upstream keeps requesting.
    out_ready = 1'b0; req_imm(32'h10); in_valid = 1'b1;
    tick(); req_imm(32'h20);
    tick();
    chk("pre_flush_full", {31'd0, in_ready}, 32'd0);
    req_imm(32'h30); flush = 1'b1;
    tick(); flush = 1'b0; in_valid = 1'b0;
    chk("flush_valid", {31'd0, out_valid}, 32'd0);
    chk("flush_in_ready", {31'd0, in_ready}, 32'd1);

    // Bypass push discarded by flush still counts.
    req_rs2(5'd9, 32'h0); byp_valid = 2'b01; byp_addr = {5'd0, 5'd9};
    in_valid = 1'b1; flush = 1'b1;
    tick(); in_valid = 1'b0; flush = 1'b0;
    chk("flush_discard", {31'd0, out_valid}, 32'd0);
    chk("flush_hits", {16'd0, byp_hits}, 32'd3);

    // Reset in the middle of a transfer.
    req_imm(32'h40); in_valid = 1'b1;
    tick(); tick(); in_valid = 1'b0;
    #3 reset_n = 1'b0;
    #1;
    chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_ready", {31'd0, in_ready}, 32'd1);
    chk("mid_rst_data", alu_src_b, 32'd0);
    chk("mid_rst_hits", {16'd0, byp_hits}, 32'd0);
    tick();
    #2 reset_n = 1'b1;
    out_ready = 1'b1; req_imm(32'h55); in_valid = 1'b1;
    tick(); in_valid = 1'b0;
    chk("post_rst_push", alu_src_b, 32'h55);
    chk("post_rst_valid", {31'd0, out_valid}, 32'd1);
    tick();

    // Saturation of the hit counter.
    force dut.r_byp_hits = 16'hFFFE;
    #1;
    release dut.r_byp_hits;
    #1;
    chk("hits_preset", {16'd0, byp_hits}, 32'h0000FFFE);
    req_rs2(5'd3, 32'h0); byp_valid = 2'b01; byp_addr = {5'd0, 5'd3};
    byp_data = {32'h0, 32'hC3}; in_valid = 1'b1;
    tick();
    chk("sat_first", {16'd0, byp_hits}, 32'h0000FFFF);
    chk("sat_data", alu_src_b, 32'hC3);
    tick(); tick(); in_valid = 1'b0;
    chk("sat_no_wrap", {16'd0, byp_hits}, 32'h0000FFFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
